// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary ROWS x COLS PE array: clears the
// accumulators, streams k_len operands, flushes the skew and drains each row.
module systolic_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      feed_stall,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      clr,
  output logic                      en,
  output logic                      feed_valid,
  output logic [KW-1:0]             k_idx,
  output logic                      out_valid,
  output logic [$clog2(ROWS):0]     out_row,
  output logic                      done
);

  localparam int RW        = $clog2(ROWS) + 1;
  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FW        = $clog2(ROWS + COLS) + 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] k_idx_q, k_idx_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          busy_q, busy_d;
  logic          clr_q, clr_d;
  logic          en_q, en_d;
  logic          fv_q, fv_d;
  logic          ov_q, ov_d;
  logic          done_q, done_d;

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    k_idx_d = k_idx_q;
    flush_d = flush_q;
    row_d   = row_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          klen_d  = k_len;
          state_d = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_STREAM;
      S_STREAM: begin
        // en_q high means the current cycle actually issued k_idx_q.
        if (en_q) begin
          if (k_idx_q == klen_q - KW'(1)) begin
            flush_d = '0;
            state_d = (FLUSH_LEN == 0) ? S_DRAIN : S_FLUSH;
          end else begin
            k_idx_d = k_idx_q + KW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (en_q) begin
          if (flush_q == FLUSH_LAST) state_d = S_DRAIN;
          else                       flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) state_d = S_DONE;
          else                   row_d   = row_q + RW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Indices read as zero whenever their phase is not active.
    if (state_d != S_STREAM) k_idx_d = '0;
    if (state_d != S_DRAIN)  row_d   = '0;

    // A stall seen at the edge makes the following cycle idle for the array.
    busy_d = (state_d != S_IDLE);
    clr_d  = (state_d == S_CLEAR);
    en_d   = ((state_d == S_STREAM) || (state_d == S_FLUSH)) && !feed_stall;
    fv_d   = (state_d == S_STREAM) && !feed_stall;
    ov_d   = (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      k_idx_q <= '0;
      flush_q <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      fv_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      k_idx_q <= k_idx_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      fv_q    <= fv_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign clr        = clr_q;
  assign en         = en_q;
  assign feed_valid = fv_q;
  assign k_idx      = k_idx_q;
  assign out_valid  = ov_q;
  assign out_row    = row_q;
  assign done       = done_q;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter ROWS, default 4: PE array rows; legal range 1..64.
REQ-002 Parameter COLS, default 4: PE array columns; legal range 1..64.
REQ-003 Parameter KW, default 16: width of the reduction-length field.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  begin tile; sampled only in IDLE.
REQ-007 k_len  in  KW  reduction depth; latched when start is accepted.
REQ-008 feed_stall  in  1  operand feeder not ready; freezes STREAM/FLUSH.
REQ-009 out_ready  in  1  result sink accepts the current row.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 clr  out  1  broadcast accumulator clear to all PEs.
REQ-012 en  out  1  broadcast MAC enable to all PEs.
REQ-013 feed_valid  out  1  feeder must present real operands at the array edge.
REQ-014 k_idx  out  KW  operand index the feeder presents this cycle.
REQ-015 out_valid  out  1  acc row out_row is presented for drain.
REQ-016 out_row  out  $clog2(ROWS)+1  row index being drained.
REQ-017 done  out  1  one-cycle pulse: tile complete.

Function
REQ-018 States are IDLE, CLEAR, STREAM, FLUSH, DRAIN and DONE; all outputs are registered, decoded from next state.
REQ-019 IDLE: start=1 with k_len!=0 -> CLEAR; start=1 with k_len==0 -> DONE (no clr, no en); otherwise stay.
REQ-020 start while not IDLE is ignored, and the latched k_len does not change.
REQ-021 CLEAR lasts exactly 1 cycle: clr=1, en=0 -> STREAM; feed_stall has no effect in CLEAR.
REQ-022 STREAM: en=1, feed_valid=1, k_idx counts 0..k_len-1 (one per unstalled cycle) -> FLUSH after index k_len-1 is issued.
REQ-023 FLUSH: en=1, feed_valid=0 (feeder drives zeros), k_idx=0; lasts ROWS+COLS-2 unstalled cycles to drain skew (PE PIPE=1); if ROWS+COLS-2==0, STREAM -> DRAIN directly.
REQ-024 feed_stall=1 in STREAM/FLUSH: en=0 and feed_valid=0 that cycle; counters and k_idx hold; no accumulation occurs.
REQ-025 DRAIN: en=0, out_valid=1, out_row starts at 0 and increments on out_valid&&out_ready; after row ROWS-1 is accepted -> DONE.
REQ-026 out_valid high with out_ready low holds out_row and out_valid stable, with no timeout.
REQ-027 DONE lasts 1 cycle: done=1, busy=1 -> IDLE; a start in the DONE cycle is ignored.
REQ-028 clr and en are never high in the same cycle.
REQ-029 Counters are wide enough for k_len = 2^KW-1 with no wrap; k_len = 2^KW-1 streams exactly 2^KW-1 cycles.
REQ-030 Unstalled latency from start accepted to done pulse is 1+k_len+(ROWS+COLS-2)+ROWS+1 cycles (out_ready held high).

Reset
REQ-031 rst_n=0 forces IDLE immediately, without waiting for a clock edge: busy, clr, en, feed_valid, out_valid and done are 0, and k_idx, out_row and the latched k_len are 0.
REQ-032 Reset mid-tile abandons the tile with no done pulse; the first start after rst_n rises is accepted normally.

Verification (ROWS=COLS=4, KW=16)
REQ-033 start, k_len=3, no stall, out_ready=1 -> clr for 1 cycle; en for 9 cycles; feed_valid for the first 3 of those with k_idx 0,1,2; out_row 0..3 on 4 cycles; done 15 cycles after the start edge.
REQ-034 k_len=3, feed_stall=1 for 2 cycles at k_idx=1 -> en and feed_valid low for those 2 cycles, k_idx holds at 1; total tile time rises by exactly 2.
REQ-035 start, k_len=0 -> done one cycle later; clr, en and out_valid never assert.
REQ-036 DRAIN with out_ready low for 3 cycles at row 2 -> out_row=2 and out_valid=1 held; rows 3 and done follow after release.
REQ-037 start pulsed again during STREAM with k_len=7 -> ignored; original k_len=3 sequence completes unchanged.
REQ-038 rst_n low during FLUSH -> all outputs 0 asynchronously, no done; next start with k_len=2 completes in 14 cycles.
